// File: rtl/mult256_sync.sv
// mult256_sync: fully pipelined unsigned N_BITS x N_BITS -> 2*N_BITS multiplier, 2-cycle latency.
// Optional MULT256_VALID_EN adds in_valid/out_valid; stage loads are then gated by the stage valid.
module mult256_sync #(
  parameter int N_BITS    = 256,
  parameter int LIMB_BITS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef MULT256_VALID_EN
  input  logic                in_valid,
  output logic                out_valid,
`endif
  input  logic [N_BITS-1:0]   num1,
  input  logic [N_BITS-1:0]   num2,
  output logic [2*N_BITS-1:0] product
);

  localparam int PW    = 2 * N_BITS;
  localparam int NL    = N_BITS / LIMB_BITS;
  localparam int NPP   = NL * NL;
  localparam int LVLS  = (NPP > 1) ? $clog2(NPP) : 0;
  localparam int NLEAF = 1 << LVLS;

  logic [N_BITS-1:0] a_reg;
  logic [N_BITS-1:0] b_reg;
  logic [PW-1:0]     product_reg;
  logic [PW-1:0]     sum_next;
  logic              ld1;
  logic              ld2;

`ifdef MULT256_VALID_EN
  logic v1_reg;
  logic v2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      v1_reg <= in_valid;
      v2_reg <= v1_reg;
    end
  end

  assign ld1       = in_valid;
  assign ld2       = v1_reg;
  assign out_valid = v2_reg;
`else
  assign ld1 = 1'b1;
  assign ld2 = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (ld1) begin
      a_reg <= num1;
      b_reg <= num2;
    end
  end

  // Balanced adder tree: level 0 holds the shifted limb products (padded to a power of two),
  // each higher level sums adjacent pairs. Full width everywhere, so no carry is ever lost.
  genvar gl, gi;
  generate
    for (gl = 0; gl <= LVLS; gl++) begin : g_lvl
      localparam int W = NLEAF >> gl;
      logic [PW-1:0] node [0:W-1];

      if (gl == 0) begin : g_leaf
        for (gi = 0; gi < W; gi++) begin : g_pp
          if (gi < NPP) begin : g_real
            localparam int LI = gi / NL;
            localparam int LJ = gi % NL;
            logic [2*LIMB_BITS-1:0] pp;
            assign pp = {{LIMB_BITS{1'b0}}, a_reg[LI*LIMB_BITS +: LIMB_BITS]} *
                        {{LIMB_BITS{1'b0}}, b_reg[LJ*LIMB_BITS +: LIMB_BITS]};
            assign node[gi] = PW'(pp) << ((LI + LJ) * LIMB_BITS);
          end else begin : g_pad
            assign node[gi] = '0;
          end
        end
      end else begin : g_sum
        for (gi = 0; gi < W; gi++) begin : g_add
          assign node[gi] = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
        end
      end
    end
  endgenerate

  assign sum_next = g_lvl[LVLS].node[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg <= '0;
    end else if (ld2) begin
      product_reg <= sum_next;
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_mult256_sync.sv
// tb_mult256_sync: randomized self-checking bench for mult256_sync against an a*b reference.
// Builds with or without MULT256_VALID_EN.
`timescale 1ns/1ps
module tb_mult256_sync;
  localparam int N = 256;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   num1  = '0;
  logic [N-1:0]   num2  = '0;
  logic [2*N-1:0] product;
`ifdef MULT256_VALID_EN
  logic           in_valid = 1'b0;
  logic           out_valid;
`endif

  int nvec  = 0;
  int nfail = 0;

  // Reference state: what the product should read, plus the pair captured one edge ago.
  logic [2*N-1:0] exp_prod   = '0;
  logic [2*N-1:0] prev_prod  = '0;
  logic           prev_valid = 1'b0;
  logic           exp_ov     = 1'b0;

  always #5 clk = ~clk;

  mult256_sync #(.N_BITS(N), .LIMB_BITS(64)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef MULT256_VALID_EN
    .in_valid (in_valid),
    .out_valid(out_valid),
`endif
    .num1    (num1),
    .num2    (num2),
    .product (product)
  );

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] ea;
    logic [2*N-1:0] eb;
    ea = {{N{1'b0}}, a};
    eb = {{N{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [N-1:0] rnd256();
    logic [N-1:0] r;
    for (int i = 0; i < N/32; i++) r[32*i +: 32] = $urandom;
    case ($urandom_range(0, 15))
      0: r = '0;
      1: r = '1;
      2: r = {{(N-1){1'b0}}, 1'b1};
      default: ;
    endcase
    return r;
  endfunction

  task automatic reset_model();
    exp_prod   = '0;
    prev_prod  = '0;
    prev_valid = 1'b0;
    exp_ov     = 1'b0;
  endtask

  // Apply one pair, take one edge, and advance the reference: the product after an edge
  // is the most recent valid pair captured at the previous edge, otherwise it holds.
  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic v);
    num1 = a;
    num2 = b;
`ifdef MULT256_VALID_EN
    in_valid = v;
`endif
    @(posedge clk);
    #1;
    exp_ov = prev_valid;
    if (prev_valid) exp_prod = prev_prod;
    prev_valid = v;
    prev_prod  = ref_mul(a, b);
  endtask

  task automatic test_reset();
    logic [N-1:0] x1, y1, x2, y2;
    x1 = rnd256() | 256'h1; y1 = rnd256() | 256'h1;
    x2 = rnd256();          y2 = rnd256();
    num1 = rnd256(); num2 = rnd256();
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (product !== '0) begin
      nfail++; $display("FAIL reset_async: got %h want 0", product);
    end
    @(posedge clk); #1;
    nvec++;
    if (product !== '0) begin
      nfail++; $display("FAIL reset_edge: got %h want 0", product);
    end
    rst_n = 1'b1;
    reset_model();
    step(x1, y1, 1'b1);
    nvec++;
    if (product !== '0) begin
      nfail++; $display("FAIL reset_release_edge1: got %h want 0", product);
    end
    step(x2, y2, 1'b1);
    nvec++;
    if (product !== ref_mul(x1, y1)) begin
      nfail++; $display("FAIL reset_release_edge2: got %h want %h", product, ref_mul(x1, y1));
    end
    $display("test_reset: done");
  endtask

  task automatic test_max();
    logic [N-1:0]   m;
    logic [2*N-1:0] want;
    m    = '1;
    want = {{(N-1){1'b1}}, 1'b0, {(N-1){1'b0}}, 1'b1};
    step(m, m, 1'b1);
    step('0, '0, 1'b1);
    nvec++;
    if (product !== want) begin
      nfail++; $display("FAIL max_square: got %h want %h", product, want);
    end
    $display("test_max: product=%h", product);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b, one;
    a   = {16{16'h1234}};
    b   = {16{16'hABCD}};
    one = {{(N-1){1'b0}}, 1'b1};
    step(a, b, 1'b1);
    step(one, b, 1'b1);
    nvec++;
    if (product !== ref_mul(a, b)) begin
      nfail++; $display("FAIL b2b_AxB: got %h want %h", product, ref_mul(a, b));
    end
    step(a, one, 1'b1);
    nvec++;
    if (product !== {{N{1'b0}}, b}) begin
      nfail++; $display("FAIL b2b_1xB: got %h want %h", product, {{N{1'b0}}, b});
    end
    step('0, '0, 1'b1);
    nvec++;
    if (product !== {{N{1'b0}}, a}) begin
      nfail++; $display("FAIL b2b_Ax1: got %h want %h", product, {{N{1'b0}}, a});
    end
    $display("test_back_to_back: done");
  endtask

  task automatic test_boundaries();
    logic [N-1:0]   m, x, half, two, one;
    logic [2*N-1:0] p2n;
    m    = '1;
    x    = rnd256() | {1'b1, {(N-1){1'b0}}};
    half = {1'b1, {(N-1){1'b0}}};
    two  = {{(N-2){1'b0}}, 2'b10};
    one  = {{(N-1){1'b0}}, 1'b1};
    p2n  = {{(N-1){1'b0}}, 1'b1, {N{1'b0}}};
    step('0, m, 1'b1);
    step(half, two, 1'b1);
    nvec++;
    if (product !== '0) begin
      nfail++; $display("FAIL bound_0xmax: got %h want 0", product);
    end
    step(x, one, 1'b1);
    nvec++;
    if (product !== p2n) begin
      nfail++; $display("FAIL bound_2^255x2: got %h want %h", product, p2n);
    end
    step(x, '0, 1'b1);
    nvec++;
    if (product !== {{N{1'b0}}, x}) begin
      nfail++; $display("FAIL bound_xx1: got %h want %h", product, {{N{1'b0}}, x});
    end
    // Wiggle the operands between edges; only the value present at the edge may count.
    num1 = rnd256(); num2 = rnd256();
    #3;
    step(m, one, 1'b1);
    nvec++;
    if (product !== '0) begin
      nfail++; $display("FAIL bound_xx0: got %h want 0", product);
    end
    step('0, '0, 1'b1);
    nvec++;
    if (product !== {{N{1'b0}}, m}) begin
      nfail++; $display("FAIL bound_glitch: got %h want %h", product, {{N{1'b0}}, m});
    end
    $display("test_boundaries: done");
  endtask

  task automatic test_reset_midstream();
    logic [N-1:0] a1, b1, a2, b2, a3, b3;
    a1 = rnd256() | 256'h1; b1 = rnd256() | 256'h1;
    a2 = rnd256() | 256'h3; b2 = rnd256() | 256'h5;
    a3 = rnd256();          b3 = rnd256();
    step(a1, b1, 1'b1);
    step(a1, b1, 1'b1);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (product !== '0) begin
      nfail++; $display("FAIL mid_reset_async: got %h want 0", product);
    end
    #2 rst_n = 1'b1;
    reset_model();
    step(a2, b2, 1'b1);
    nvec++;
    if (product !== '0) begin
      nfail++; $display("FAIL mid_reset_flush: got %h want 0", product);
    end
    step(a3, b3, 1'b1);
    nvec++;
    if (product !== ref_mul(a2, b2)) begin
      nfail++; $display("FAIL mid_reset_pair2: got %h want %h", product, ref_mul(a2, b2));
    end
    step('0, '0, 1'b1);
    nvec++;
    if (product !== ref_mul(a3, b3)) begin
      nfail++; $display("FAIL mid_reset_pair3: got %h want %h", product, ref_mul(a3, b3));
    end
    $display("test_reset_midstream: done");
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 1000; i++) begin
      v = 1'b1;
`ifdef MULT256_VALID_EN
      v = ($urandom_range(0, 3) != 0);
`endif
      step(rnd256(), rnd256(), v);
      nvec++;
      if (product !== exp_prod) begin
        nfail++; $display("FAIL random_%0d: got %h want %h", i, product, exp_prod);
      end
`ifdef MULT256_VALID_EN
      nvec++;
      if (out_valid !== exp_ov) begin
        nfail++; $display("FAIL random_valid_%0d: got %b want %b", i, out_valid, exp_ov);
      end
`endif
    end
    $display("test_random: 1000 pairs applied");
  endtask

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_boundaries();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
